prf_read_arbiter: RTL
=====================

Name: prf_read_arbiter

Overview:
- Shares a fixed pool of physical-register-file read ports among the three issue queues: ALU, branch and memory.
- Each cycle it selects which issuing instructions get PRF reads and drives the port enables and tags.
- It captures the returned operands and the instruction into a per-FU output register with a valid/ready handshake.
- It sits between the reservation stations and the FUs, in place of a fixed one-pair-of-ports-per-FU hookup.

Parameters:
- NUM_PORTS, 4, number of PRF read ports; legal range 2..6.
- NUM_REQ, 3, number of requesters, fixed: 0=ALU, 1=branch, 2=mem.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush
- req_valid  in  [NUM_REQ]  RS has an instruction to issue
- req_data  in  rs_data[NUM_REQ]  issued entry; uses .valid, .ps1, .ps2 (7b)
- req_ready  out  [NUM_REQ]  accepted this cycle
- rd_en  out  [NUM_PORTS]  PRF read enable
- rd_tag  out  [NUM_PORTS][6:0]  PRF read address
- rd_data  in  [NUM_PORTS][31:0]  PRF combinational read data, same cycle
- out_valid  out  [NUM_REQ]  operands ready for FU
- out_data  out  rs_data[NUM_REQ]  registered entry
- out_ps1_data  out  [NUM_REQ][31:0]  source 1 value
- out_ps2_data  out  [NUM_REQ][31:0]  source 2 value
- out_ready  in  [NUM_REQ]  FU consumes

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Port need per requester: count of ps1/ps2 that are nonzero (0..2). p0 reads as 32'h0 and consumes no port.
- Eligibility of requester i: req_valid[i] && req_data[i].valid && (!out_valid[i] || out_ready[i]).
- Allocation, combinational each cycle:
  - Visit requesters in rotating order starting at rr_ptr.
  - Grant each eligible requester while cumulative need <= NUM_PORTS.
  - Stop at the first eligible requester that does not fit; later requesters are not granted that cycle, so no skipping.
  - Ports are assigned in visit order, ps1 before ps2, starting at port 0.
  - Unused ports: rd_en=0, rd_tag=0.
- req_ready[i] = grant[i]. Grant depends on req_valid; requesters must not make req_valid depend on req_ready.
- Latency: an instruction accepted in cycle N has out_valid=1 in cycle N+1, with out_data and operand values captured from rd_data in cycle N.
- Output hold: while out_valid[i] && !out_ready[i], the slot holds all fields stable and req_ready[i]=0.
- Output clear: out_valid[i] clears on out_ready unless a new grant refills the slot in the same cycle. Back-to-back issue every cycle is supported.
- rr_ptr:
  - If any grant, rr_ptr <= (index of last granted requester + 1) mod 3.
  - Otherwise rr_ptr is unchanged.
  - Wrap 2 -> 0.
- flush:
  - All req_ready=0 and rd_en=0 that cycle.
  - All out_valid <= 0.
  - rr_ptr unchanged.
  - flush has priority over grant and over out_ready.
- Reset values: out_valid=0, out_data='0, out_ps*_data=0, rr_ptr=0. Combinational outputs are 0 during reset: req_ready, rd_en, rd_tag.
- Reset mid-operation: in-flight outputs are dropped and no handshake completes.
- Simultaneous need of 6 with NUM_PORTS=6: all three granted.

Optional Feature:
- Macro: PRF_WB_BYPASS_EN.
- Enabled, extra ports:
  - wb_valid  in  1
  - wb_tag  in  [6:0]
  - wb_data  in  [31:0]
- Enabled behaviour:
  - When wb_valid && wb_tag == ps && ps != 0 in the grant cycle, the captured operand is wb_data instead of rd_data.
  - Port allocation is unchanged.
- Disabled: the wb ports are absent and operands come only from rd_data (or 0 for p0).

Decomposition:
- types_pkg:
  - Requester index constants REQ_ALU=0, REQ_BR=1, REQ_MEM=2.
  - NUM_REQ.
  - A port-assignment struct: valid, req idx, src sel.
  - rs_data is reused unchanged.
- Sub-module: prf_port_alloc, purely combinational. Inputs: needs, eligibility, rr_ptr. Outputs: grants and per-port assignment.
- The top level holds rr_ptr, the output registers, flush and bypass.

Test Plan:
- rr_ptr=0, all three request with nonzero ps1/ps2, NUM_PORTS=4 -> grant ALU+BR on ports 0-3, MEM req_ready=0; next cycle rr_ptr=2, MEM granted first on ports 0-1.
- ALU ps1=0/ps2=5, BR ps1=3/ps2=4, MEM ps1=9/ps2=0 -> all granted on 4 ports; ALU out_ps1_data=0, rd_tag={5,3,4,9}.
- Grant ALU, then out_ready[0]=0 for 3 cycles with req_valid[0]=1 -> req_ready[0]=0 and out_* stable; out_ready=1 -> next ALU issue accepted the same cycle.
- out_valid on all three slots, assert flush with out_ready=1 -> no FU handshake counted, out_valid all 0 next cycle, rr_ptr unchanged.
- PRF_WB_BYPASS_EN: wb_valid=1, wb_tag=7, wb_data=32'hDEAD_BEEF, BR ps2=7 -> out_ps2_data[1]=32'hDEADBEEF regardless of rd_data.
- reset asserted one cycle after a grant -> out_valid=0, rr_ptr=0, rd_en=0, no stale output after reset deasserts.

Source files
------------

// File: rtl/prf_read_arbiter_pkg.sv
// Shared types for the PRF read-port arbiter: requester indices, the issued
// reservation-station entry and the per-port assignment record.
package prf_read_arbiter_pkg;

    localparam int NUM_REQ = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_BR  = 1;
    localparam int REQ_MEM = 2;

    // Issued reservation-station entry as produced by every issue queue
    typedef struct packed {
        logic       valid;
        logic [5:0] op;
        logic [6:0] pd;
        logic [6:0] ps1;
        logic [6:0] ps2;
    } rs_data;

    // Which source operand of a requester a read port serves
    typedef enum logic {
        SRC_PS1 = 1'b0,
        SRC_PS2 = 1'b1
    } src_sel_e;

    // One read port's owner for the current cycle
    typedef struct packed {
        logic       valid;
        logic [1:0] req;
        src_sel_e   src;
    } port_asg_t;

    // Rotating successor over the three requesters, wrapping 2 -> 0
    function automatic logic [1:0] next_req(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/prf_read_arbiter_if.sv
// Bundle of the issue-queue, PRF read-port and FU output signals of the
// arbiter. The write-back bypass signals exist only when PRF_WB_BYPASS_EN
// is defined.
interface prf_read_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    import prf_read_arbiter_pkg::*;

    logic [NUM_REQ-1:0]              req_valid;
    rs_data [NUM_REQ-1:0]            req_data;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_PORTS-1:0]            rd_en;
    logic [NUM_PORTS-1:0][6:0]       rd_tag;
    logic [NUM_PORTS-1:0][31:0]      rd_data;
    logic [NUM_REQ-1:0]              out_valid;
    rs_data [NUM_REQ-1:0]            out_data;
    logic [NUM_REQ-1:0][31:0]        out_ps1_data;
    logic [NUM_REQ-1:0][31:0]        out_ps2_data;
    logic [NUM_REQ-1:0]              out_ready;
`ifdef PRF_WB_BYPASS_EN
    logic                            wb_valid;
    logic [6:0]                      wb_tag;
    logic [31:0]                     wb_data;

    modport master (
        output req_valid, req_data, rd_data, out_ready, wb_valid, wb_tag, wb_data,
        input  req_ready, rd_en, rd_tag, out_valid, out_data, out_ps1_data, out_ps2_data
    );

    modport slave (
        input  req_valid, req_data, rd_data, out_ready, wb_valid, wb_tag, wb_data,
        output req_ready, rd_en, rd_tag, out_valid, out_data, out_ps1_data, out_ps2_data
    );
`else
    modport master (
        output req_valid, req_data, rd_data, out_ready,
        input  req_ready, rd_en, rd_tag, out_valid, out_data, out_ps1_data, out_ps2_data
    );

    modport slave (
        input  req_valid, req_data, rd_data, out_ready,
        output req_ready, rd_en, rd_tag, out_valid, out_data, out_ps1_data, out_ps2_data
    );
`endif

endinterface

// File: rtl/prf_read_arbiter_port_alloc.sv
// Combinational read-port allocator. Walks the requesters in rotating order
// from rr_ptr, grants each eligible one while its ports still fit, and stops
// at the first eligible requester that does not fit so nobody is skipped.
// Ports are handed out in visit order, ps1 before ps2, from port 0 upward.
module prf_read_arbiter_port_alloc
    import prf_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_REQ-1:0][1:0]  need_mask,
    input  logic [NUM_REQ-1:0]       elig,
    input  logic [1:0]               rr_ptr,
    output logic [NUM_REQ-1:0]       grant,
    output port_asg_t [NUM_PORTS-1:0] port_asg,
    output logic                     any_grant,
    output logic [1:0]               last_req
);

    localparam int CW = $clog2(NUM_PORTS + 3);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [CW-1:0] used;
    logic [CW-1:0] need;
    logic          blocked;
    logic [1:0]    idx;

    // Rotating in-order allocation with no skipping past a blocked requester
    always_comb begin
        grant     = '0;
        port_asg  = '0;
        any_grant = 1'b0;
        last_req  = 2'd0;
        used      = '0;
        need      = '0;
        blocked   = 1'b0;
        idx       = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            need = CW'(need_mask[idx][0]) + CW'(need_mask[idx][1]);
            if (elig[idx] && !blocked) begin
                if ((used + need) <= CW'(NUM_PORTS)) begin
                    grant[idx] = 1'b1;
                    any_grant  = 1'b1;
                    last_req   = idx;
                    if (need_mask[idx][0]) begin
                        port_asg[used[PW-1:0]] = '{valid: 1'b1, req: idx, src: SRC_PS1};
                        used = used + CW'(1);
                    end
                    if (need_mask[idx][1]) begin
                        port_asg[used[PW-1:0]] = '{valid: 1'b1, req: idx, src: SRC_PS2};
                        used = used + CW'(1);
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
            idx = next_req(idx);
        end
    end

endmodule

// File: rtl/prf_read_arbiter.sv
// PRF read-port arbiter: shares NUM_PORTS read ports among the ALU, branch
// and memory issue queues and registers the granted entry with its operands
// into a per-FU output slot with valid/ready handshake.
// Optional write-back bypass: define PRF_WB_BYPASS_EN.
module prf_read_arbiter
    import prf_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    prf_read_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]        out_valid_q;
    rs_data [NUM_REQ-1:0]      out_data_q;
    logic [NUM_REQ-1:0][31:0]  ps1_q;
    logic [NUM_REQ-1:0][31:0]  ps2_q;
    logic [1:0]                rr_ptr;

    logic [NUM_REQ-1:0][1:0]   need_mask;
    logic [NUM_REQ-1:0]        elig;
    logic [NUM_REQ-1:0]        grant;
    port_asg_t [NUM_PORTS-1:0] port_asg;
    logic                      any_grant;
    logic [1:0]                last_req;
    logic [NUM_REQ-1:0][31:0]  op1;
    logic [NUM_REQ-1:0][31:0]  op2;

    // Port need and eligibility; reset and flush suppress every grant
    always_comb begin
        need_mask = '0;
        elig      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            need_mask[i] = {bus.req_data[i].ps2 != 7'd0, bus.req_data[i].ps1 != 7'd0};
            elig[i]      = !reset && !flush && bus.req_valid[i] && bus.req_data[i].valid &&
                           (!out_valid_q[i] || bus.out_ready[i]);
        end
    end

    prf_read_arbiter_port_alloc #(
        .NUM_PORTS (NUM_PORTS)
    ) u_alloc (
        .need_mask (need_mask),
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .port_asg  (port_asg),
        .any_grant (any_grant),
        .last_req  (last_req)
    );

    // Drive PRF read enables and tags from the port assignment
    always_comb begin
        bus.rd_en  = '0;
        bus.rd_tag = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_asg[p].valid) begin
                bus.rd_en[p]  = 1'b1;
                bus.rd_tag[p] = (port_asg[p].src == SRC_PS2) ? bus.req_data[port_asg[p].req].ps2
                                                             : bus.req_data[port_asg[p].req].ps1;
            end
        end
    end

    // Route read data back to each requester's operands; p0 stays zero
    always_comb begin
        op1 = '0;
        op2 = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_asg[p].valid) begin
                if (port_asg[p].src == SRC_PS1) begin
                    op1[port_asg[p].req] = bus.rd_data[p];
                end else begin
                    op2[port_asg[p].req] = bus.rd_data[p];
                end
            end
        end
`ifdef PRF_WB_BYPASS_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.wb_valid && (bus.req_data[i].ps1 != 7'd0) && (bus.wb_tag == bus.req_data[i].ps1)) begin
                op1[i] = bus.wb_data;
            end
            if (bus.wb_valid && (bus.req_data[i].ps2 != 7'd0) && (bus.wb_tag == bus.req_data[i].ps2)) begin
                op2[i] = bus.wb_data;
            end
        end
`endif
    end

    // Output slots and round-robin pointer; flush beats grant and out_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            ps1_q       <= '0;
            ps2_q       <= '0;
            rr_ptr      <= 2'd0;
        end else if (flush) begin
            out_valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    out_valid_q[i] <= 1'b1;
                    out_data_q[i]  <= bus.req_data[i];
                    ps1_q[i]       <= op1[i];
                    ps2_q[i]       <= op2[i];
                end else if (bus.out_ready[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr <= next_req(last_req);
            end
        end
    end

    assign bus.req_ready    = grant;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_ps1_data = ps1_q;
    assign bus.out_ps2_data = ps2_q;

endmodule
